// File: rtl/sram_cmd_seq.sv
// sram_cmd_seq: user-command sequencer in front of the SRAM controller.
// Synchronizes switches, debounces the write/read buttons, and turns each
// accepted press into one fixed-length active-low strobe sequence.
// Optional build macro: SRAM_CMD_AUTOREAD_EN (write followed by automatic read-back).
//
// state  | meaning
// IDLE   | strobes released, waiting for a press event
// SETUP  | CE low, address/data latched on entry
// WRITE  | CE and WE low for WR_CYCLES clocks
// READ   | CE and OE low for RD_CYCLES clocks
// HOLD   | CE low, WE/OE released, one clock
// GAP    | (autoread only) one idle-strobe clock before the read-back
module sram_cmd_seq #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WR_CYCLES       = 4,
    parameter int RD_CYCLES       = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] sw_address,
    input  logic [3:0] sw_data,
    input  logic       btn_write,
    input  logic       btn_read,
    output logic [3:0] address,
    output logic [3:0] data,
    output logic       chip_enable_user,
    output logic       write_enable_user,
    output logic       output_enable_user,
    output logic       busy,
    output logic       done
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
`ifdef SRAM_CMD_AUTOREAD_EN
    localparam logic [2:0] S_GAP   = 3'd5;
`endif

    // bit 9 = read button, bit 8 = write button, [7:4] data, [3:0] address
    logic [9:0]            sync1_q, sync2_q;
    logic [1:0][DB_W-1:0]  db_cnt_q;
    logic [1:0]            db_lvl_q, db_lvl_dly_q, press_q;

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       cmd_wr_q, cmd_wr_d;
    logic [3:0] addr_q, addr_d, data_q, data_d;
    logic       ce_q, we_q, oe_q, busy_q, done_q, done_d;

    // Two-flop synchronizer for every raw board input
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_read, btn_write, sw_data, sw_address};
            sync2_q <= sync1_q;
        end
    end

    // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db_cnt_q <= '0;
            db_lvl_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[8+i] == db_lvl_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_lvl_q[i] <= sync2_q[8+i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Registered rising-edge detect of the debounced levels (bit 0 write, bit 1 read)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db_lvl_dly_q <= '0;
            press_q      <= '0;
        end else begin
            db_lvl_dly_q <= db_lvl_q;
            press_q      <= db_lvl_q & ~db_lvl_dly_q;
        end
    end

    // Sequencer next-state; presses outside IDLE are simply dropped
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_wr_d = cmd_wr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press_q[0] || press_q[1]) begin
                    state_d  = S_SETUP;
                    cmd_wr_d = press_q[0];
                    addr_d   = sync2_q[3:0];
                    data_d   = sync2_q[7:4];
                end
            end
            S_SETUP: begin
                if (cmd_wr_q) begin
                    state_d = S_WRITE;
                    cnt_d   = 8'(WR_CYCLES - 1);
                end else begin
                    state_d = S_READ;
                    cnt_d   = 8'(RD_CYCLES - 1);
                end
            end
            S_WRITE, S_READ: begin
                if (cnt_q == 8'd0) state_d = S_HOLD;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_HOLD: begin
`ifdef SRAM_CMD_AUTOREAD_EN
                if (cmd_wr_q) begin
                    state_d  = S_GAP;
                    cmd_wr_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
`else
                state_d = S_IDLE;
                done_d  = 1'b1;
`endif
            end
`ifdef SRAM_CMD_AUTOREAD_EN
            S_GAP:   state_d = S_SETUP;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State, latches and strobes registered from the next state so outputs are glitch-free
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cmd_wr_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            ce_q     <= 1'b1;
            we_q     <= 1'b1;
            oe_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_wr_q <= cmd_wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ce_q     <= !(state_d == S_SETUP || state_d == S_WRITE ||
                          state_d == S_READ  || state_d == S_HOLD);
            we_q     <= (state_d != S_WRITE);
            oe_q     <= (state_d != S_READ);
            busy_q   <= (state_d != S_IDLE);
            done_q   <= done_d;
        end
    end

    assign address            = addr_q;
    assign data               = data_q;
    assign chip_enable_user   = ce_q;
    assign write_enable_user  = we_q;
    assign output_enable_user = oe_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: doc/sram_cmd_seq.md
# sram_cmd_seq

User-command sequencer that sits directly upstream of the SRAM controller and drives its user-side inputs. It synchronizes the board switches, debounces the write/read push buttons, and turns each accepted press into one correctly ordered, fixed-length active-low strobe sequence. The sequence asserts chip enable first, then the write or output enable pulse, then releases both. Address and data stay stable for the whole sequence.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable samples required to accept a button level; board builds use 500000.
- WR_CYCLES, 4: length of write_enable_user low pulse, in clocks; legal range 1..255.
- RD_CYCLES, 4: length of output_enable_user low pulse, in clocks; legal range 1..255.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sw_address  in  4  raw address switches.
- sw_data  in  4  raw data switches.
- btn_write  in  1  raw write button; pressed = 1.
- btn_read  in  1  raw read button; pressed = 1.
- address  out  4  latched address to the controller.
- data  out  4  latched write data to the controller.
- chip_enable_user  out  1  active-low chip enable.
- write_enable_user  out  1  active-low write enable.
- output_enable_user  out  1  active-low output enable.
- busy  out  1  high while a sequence is in progress.
- done  out  1  one-clock pulse when a sequence completes.

## Operation
- All inputs pass through 2-flop synchronizers.
- Debounce, per button:
  - A counter restarts whenever the synchronized level differs from the debounced level.
  - The debounced level flips after DEBOUNCE_CYCLES consecutive differing samples.
- A press event is the registered rising edge of the debounced level. Releases generate nothing.
- FSM states:
  - IDLE: all strobes 1, busy 0.
  - SETUP: 1 clock. CE=0. address/data were latched from the synchronized switches on entry.
  - WRITE: WR_CYCLES clocks, CE=0, WE=0.
  - READ: RD_CYCLES clocks, CE=0, OE=0.
  - HOLD: 1 clock, CE=0, WE=OE=1.
- Transitions:
  - IDLE→SETUP on a press event.
  - SETUP→WRITE or READ, according to the latched command.
  - WRITE/READ→HOLD when the pulse counter expires.
  - HOLD→IDLE.
- Write and read events in the same clock: write wins, read is dropped.
- Events that occur while busy=1 are discarded, not queued.
- address/data change only on IDLE→SETUP. Switch movement mid-sequence has no effect.
- WE and OE are never low together. Neither is ever low while CE=1.

## Timing
- Reset values, asynchronous: chip_enable_user, write_enable_user, output_enable_user = 1; address = 0; data = 0; busy = 0; done = 0; FSM in IDLE; debounced levels 0; counters 0.
- Reset asserted mid-sequence releases all strobes to 1 immediately, not at the next clock edge. No done pulse is generated.
- All outputs are registered and change only on clock edges, except during reset.
- Press latency: a raw button held high from edge 0 moves the FSM to SETUP at edge DEBOUNCE_CYCLES+4.
- Write sequence: CE low for WR_CYCLES+2 clocks. WE low for exactly WR_CYCLES clocks, starting one clock after CE falls and ending one clock before CE rises.
- Read sequence: same shape as the write sequence, using RD_CYCLES and OE.
- done pulses in the first IDLE clock after HOLD. busy falls in that same clock.
- A new event can start SETUP at the earliest on the clock after done.

## Configuration
- SRAM_CMD_AUTOREAD_EN
  - Defined: after a write's HOLD state, the FSM runs one extra idle-strobe clock (CE=1), then a full READ sequence (SETUP, READ, HOLD) at the same latched address. busy stays high throughout. done pulses once, after the read-back.
  - Undefined: a write ends after HOLD, exactly as specified above.

## Test plan
Test parameters: DEBOUNCE_CYCLES=4, WR_CYCLES=4, RD_CYCLES=4.

- Reset held low 5 clocks, then released → all strobes 1, address=0, data=0, busy=0, done=0.
- sw_address=0001, sw_data=1010, btn_write held high 20 clocks → one sequence: CE low 6 clocks, WE low 4 clocks inside it, OE stays 1, address=0001, data=1010, done pulses once.
- btn_read toggles every clock for 30 clocks, then is held high → zero sequences during toggling, exactly one READ sequence after the hold (CE low 6 clocks, OE low 4 clocks).
- btn_write and btn_read rise in the same clock → a WRITE sequence only; OE never goes low.
- A read starts, sw_address changes 0010→1111 mid-pulse, and a second write press arrives during READ → address stays 0010, the write press is ignored, done pulses once.
- Reset driven low during the second WE-low clock → WE and CE return to 1 without waiting for a clock edge, no done pulse; after reset release the FSM is in IDLE.
